// File: rtl/instruction_fetch_queue.sv
// Fetch stage: self-sequencing PC, req/gnt/rvalid instruction memory port and an
// in-order queue of PC-tagged instructions feeding the IF/ID latch.
module instruction_fetch_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}},
  parameter int PC_STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   id_valid,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  input  logic                   id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Headroom for stale responses accumulated over repeated redirects against a slow memory.
  localparam int DROP_W = PTR_W + 6;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C = ADDR_WIDTH'(PC_STEP);
  localparam logic [DROP_W-1:0] DROP_ZERO = {DROP_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  slot_pc_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  slot_pc_d [DEPTH];
  logic [INSTR_WIDTH-1:0] slot_instr_q [DEPTH];
  logic [INSTR_WIDTH-1:0] slot_instr_d [DEPTH];
  logic [DEPTH-1:0]       filled_q, filled_d;
  logic [PTR_W-1:0]       alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0]       fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]       head_ptr_q, head_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       unfilled_q, unfilled_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [DROP_W-1:0]      drop_total_s;
  logic                   grant_s, fill_s, pop_s, drop_s;

  assign mem_req  = rst_n & ~redirect_valid & (count_q < DEPTH_C);
  assign mem_addr = fetch_pc_q;
  assign id_valid = filled_q[head_ptr_q] & ~redirect_valid;
  assign id_instr = slot_instr_q[head_ptr_q];
  assign id_pc    = slot_pc_q[head_ptr_q];

  assign grant_s = mem_req & mem_gnt;
  assign pop_s   = id_valid & id_ready;
  assign drop_s  = mem_rvalid & (drop_cnt_q != DROP_ZERO);
  // A response with nothing owed and nothing unfilled is a protocol error and is ignored.
  assign fill_s  = mem_rvalid & (drop_cnt_q == DROP_ZERO) & (unfilled_q != CNT_ZERO) & ~redirect_valid;

  // Next-state for PC, slot storage, pointers, occupancy and stale-response accounting.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    filled_d     = filled_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    head_ptr_d   = head_ptr_q;
    count_d      = count_q;
    unfilled_d   = unfilled_q;
    drop_cnt_d   = drop_cnt_q;
    drop_total_s = drop_cnt_q + DROP_W'(unfilled_q);
    if (redirect_valid) begin
      fetch_pc_d  = redirect_pc;
      filled_d    = {DEPTH{1'b0}};
      alloc_ptr_d = {PTR_W{1'b0}};
      fill_ptr_d  = {PTR_W{1'b0}};
      head_ptr_d  = {PTR_W{1'b0}};
      count_d     = CNT_ZERO;
      unfilled_d  = CNT_ZERO;
      if (mem_rvalid && (drop_total_s != DROP_ZERO)) begin
        drop_cnt_d = drop_total_s - DROP_W'(1);
      end else begin
        drop_cnt_d = drop_total_s;
      end
    end else begin
      if (grant_s) begin
        slot_pc_d[alloc_ptr_q] = fetch_pc_q;
        filled_d[alloc_ptr_q]  = 1'b0;
        alloc_ptr_d            = alloc_ptr_q + PTR_ONE;
        fetch_pc_d             = fetch_pc_q + STEP_C;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (fill_s) begin
        slot_instr_d[fill_ptr_q] = mem_rdata;
        filled_d[fill_ptr_q]     = 1'b1;
        fill_ptr_d               = fill_ptr_q + PTR_ONE;
      end else begin
        fill_ptr_d = fill_ptr_q;
      end
      if (pop_s) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + PTR_ONE;
      end else begin
        head_ptr_d = head_ptr_q;
      end
      if (drop_s) begin
        drop_cnt_d = drop_cnt_q - DROP_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      count_d    = count_q + CNT_W'(grant_s) - CNT_W'(pop_s);
      unfilled_d = unfilled_q + CNT_W'(grant_s) - CNT_W'(fill_s);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      slot_pc_q    <= '{default: {ADDR_WIDTH{1'b0}}};
      slot_instr_q <= '{default: {INSTR_WIDTH{1'b0}}};
      filled_q     <= {DEPTH{1'b0}};
      alloc_ptr_q  <= {PTR_W{1'b0}};
      fill_ptr_q   <= {PTR_W{1'b0}};
      head_ptr_q   <= {PTR_W{1'b0}};
      count_q      <= CNT_ZERO;
      unfilled_q   <= CNT_ZERO;
      drop_cnt_q   <= DROP_ZERO;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      filled_q     <= filled_d;
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      head_ptr_q   <= head_ptr_d;
      count_q      <= count_d;
      unfilled_q   <= unfilled_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: queue-level reference model checked every cycle,
// a latency-configurable memory responder, and literal expectations per scenario.
module tb_instruction_fetch_queue;

  localparam int AW = 16;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic          clk, rst_n;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          mem_req, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata;
  logic          id_valid, id_ready;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;

  instruction_fetch_queue #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] instr; bit filled; } ent_t;
  typedef struct { int due; logic [IW-1:0] data; } rsp_t;

  // reference model: queue of allocated entries, next fetch PC, stale responses owed
  ent_t          m_q[$];
  logic [AW-1:0] m_pc;
  int            m_drop;

  rsp_t          mem_q[$];
  logic [AW-1:0] pop_log[$];
  int            lat, cyc, grants, first_grant, first_pop;
  int            checks, failures;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_pop(input int idx, input logic [AW-1:0] exp, input string nm);
    logic [AW-1:0] got;
    got = 'x;
    if (idx < pop_log.size()) got = pop_log[idx];
    check(nm, {48'd0, got}, {48'd0, exp});
  endtask

  function automatic logic mdl_req();
    return rst_n && !redirect_valid && (m_q.size() < DEPTH);
  endfunction

  function automatic logic mdl_valid();
    return !redirect_valid && (m_q.size() > 0) && m_q[0].filled;
  endfunction

  task automatic model_update(input logic ge);
    int unf, tot, idx;
    logic g, p;
    if (redirect_valid) begin
      unf = 0;
      foreach (m_q[i]) if (!m_q[i].filled) unf++;
      tot = m_drop + unf;
      if (mem_rvalid && tot > 0) tot--;
      m_drop = tot;
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      g = mdl_req() && ge;
      p = mdl_valid() && id_ready;
      if (mem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          idx = -1;
          foreach (m_q[i]) if (idx < 0 && !m_q[i].filled) idx = i;
          if (idx >= 0) begin
            m_q[idx].filled = 1'b1;
            m_q[idx].instr = mem_rdata;
          end
        end
      end
      if (p) void'(m_q.pop_front());
      if (g) begin
        m_q.push_back('{pc: m_pc, instr: 32'h0, filled: 1'b0});
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  // one clock cycle: entered and left at a falling edge
  task automatic step(input logic rv, input logic [AW-1:0] rpc, input logic rdy, input logic ge);
    rsp_t r;
    redirect_valid = rv;
    redirect_pc = rpc;
    id_ready = rdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata = r.data;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
    #1 mem_gnt = ge & mem_req;
    #1;
    check("mem_req", {63'd0, mem_req}, {63'd0, mdl_req()});
    if (mdl_req()) check("mem_addr", {48'd0, mem_addr}, {48'd0, m_pc});
    check("id_valid", {63'd0, id_valid}, {63'd0, mdl_valid()});
    if (mdl_valid()) begin
      check("id_pc", {48'd0, id_pc}, {48'd0, m_q[0].pc});
      check("id_instr", {32'd0, id_instr}, {32'd0, m_q[0].instr});
    end
    if (id_valid && id_ready) begin
      pop_log.push_back(id_pc);
      if (first_pop < 0) first_pop = cyc;
    end
    if (mem_req && mem_gnt) begin
      grants++;
      if (first_grant < 0) first_grant = cyc;
      mem_q.push_back('{due: cyc + lat, data: 32'hA000_0000 | {16'h0000, mem_addr}});
    end
    model_update(ge);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, rdy, 1'b1);
  endtask

  // asynchronous reset asserted mid-cycle, released on a falling edge
  task automatic reset_dut(input int new_lat);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_id_valid", {63'd0, id_valid}, 64'd0);
    check("rst_id_pc", {48'd0, id_pc}, 64'd0);
    check("rst_id_instr", {32'd0, id_instr}, 64'd0);
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    id_ready = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    m_q.delete();
    m_pc = 16'h0000;
    m_drop = 0;
    mem_q.delete();
    pop_log.delete();
    grants = 0;
    first_grant = -1;
    first_pop = -1;
    lat = new_lat;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("restart_req", {63'd0, mem_req}, 64'd1);
    check("restart_addr", {48'd0, mem_addr}, 64'd0);
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    cyc = 0;
    rst_n = 1'b0;
    @(negedge clk);

    // streaming, single-cycle memory
    reset_dut(1);
    run(12, 1'b1);
    check("stream_latency", 64'(first_pop - first_grant), 64'd2);
    check("stream_count", 64'(pop_log.size()), 64'd10);
    for (int i = 0; i < 10; i++) chk_pop(i, AW'(i), "stream_pc");

    // backpressure (reset asserted while streaming)
    reset_dut(1);
    run(10, 1'b0);
    check("bp_grants", 64'(grants), 64'd4);
    check("bp_req_low", {63'd0, mem_req}, 64'd0);
    check("bp_no_pop", 64'(pop_log.size()), 64'd0);
    run(12, 1'b1);
    for (int i = 0; i < 5; i++) chk_pop(i, AW'(i), "bp_pc");

    // variable latency
    reset_dut(4);
    run(24, 1'b1);
    check("varlat_count", {63'd0, pop_log.size() >= 12}, 64'd1);
    for (int i = 0; i < pop_log.size(); i++) chk_pop(i, AW'(i), "varlat_pc");

    // redirect with two unfilled slots in flight
    reset_dut(3);
    run(2, 1'b1);
    step(1'b1, 16'h0040, 1'b1, 1'b1);
    run(10, 1'b1);
    chk_pop(0, 16'h0040, "redir_first");
    chk_pop(1, 16'h0041, "redir_second");

    // redirect coinciding with a response and id_ready
    reset_dut(2);
    run(6, 1'b1);
    n = pop_log.size();
    step(1'b1, 16'h0080, 1'b1, 1'b1);
    check("redir_nopop", 64'(pop_log.size()), 64'(n));
    run(8, 1'b1);
    chk_pop(n, 16'h0080, "redir_rv_first");
    chk_pop(n + 1, 16'h0081, "redir_rv_second");

    // PC wrap
    reset_dut(1);
    run(3, 1'b1);
    n = pop_log.size();
    step(1'b1, 16'hFFFF, 1'b1, 1'b1);
    run(8, 1'b1);
    chk_pop(n, 16'hFFFF, "wrap_first");
    chk_pop(n + 1, 16'h0000, "wrap_second");

    // back-to-back redirects with cumulative drops
    reset_dut(3);
    run(2, 1'b1);
    step(1'b1, 16'h0010, 1'b1, 1'b1);
    step(1'b1, 16'h0020, 1'b1, 1'b1);
    run(12, 1'b1);
    chk_pop(0, 16'h0020, "b2b_first");
    chk_pop(1, 16'h0021, "b2b_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
